pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage directly upstream of the control unit. Holds the program counter, addresses the combinational program memory, and presents the current instruction's 6-bit opcode to the control unit. Applies the control unit's `s_inc` decision to choose the next PC: increment or jump to the instruction's address field. Adds stall hold, a boot cycle, and an optional return-address stack for call/return.

## Interface
Parameters:
- `PC_WIDTH`, 10, program counter and jump field width
- `INSTR_WIDTH`, 16, instruction width; opcode is `[INSTR_WIDTH-1 -: 6]`, jump target is `[PC_WIDTH-1:0]`
- `STACK_DEPTH`, 4, return-stack entries, power of two ≥ 2

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high
- `mem_data`  in  INSTR_WIDTH  program-memory word at `pc`, combinational
- `s_inc`  in  1  from the control unit: 1 = PC+1, 0 = jump
- `stall`  in  1  1 = hold PC and stack this cycle
- `call`  in  1  push PC+1 and jump
- `ret`  in  1  pop into PC
- `pc`  out  PC_WIDTH  current fetch address
- `instr`  out  INSTR_WIDTH  current instruction; 0 when not valid
- `opcode`  out  6  to the control unit; 6'b111111 (NOP) when not valid
- `instr_valid`  out  1  instruction is live this cycle
- `err`  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 call and ret together

## Operation
- FSM states: BOOT, RUN, HALTED.
- Reset: `pc`=0, stack pointer=0, `err`=00, state=BOOT. `instr_valid`=0, `opcode`=6'b111111, `instr`=0.
- BOOT lasts one cycle. PC stays 0. Inputs are ignored, including `stall`. Next state is RUN.
- RUN: `instr_valid`=1, `instr`=`mem_data`, `opcode`=`mem_data[INSTR_WIDTH-1 -: 6]`. Next-PC priority at the clock edge:
  1. `stall`: hold everything.
  2. `call`&`ret`: `err`=11, go to HALTED.
  3. `ret`: if the stack is empty, `err`=10 and go to HALTED. Otherwise PC = top and pop.
  4. `call`: if the stack is full, `err`=01 and go to HALTED. Otherwise push PC+1 and PC = `mem_data[PC_WIDTH-1:0]`.
  5. `s_inc`=0: PC = `mem_data[PC_WIDTH-1:0]`.
  6. Otherwise: PC = PC+1.
- PC arithmetic is modulo 2^PC_WIDTH. All-ones +1 wraps to 0, and a pushed return address wraps the same way.
- In HALTED, PC and stack are frozen, `instr_valid`=0, and `opcode`=6'b111111. `err` holds its value. Only `reset` leaves HALTED.
- An error is still detected while stalled, but it takes effect only once the stall drops. Stall has the highest priority.

## Timing
- PC update latency is one cycle. The opcode for the new PC is available combinationally in the following cycle.
- First valid instruction (address 0) is in the cycle after BOOT, i.e. the second cycle after reset deasserts.
- `err` and the HALTED state assert on the same edge that detects the fault.
- Reset in any state, including mid-stall or HALTED, takes effect at the next edge. Stack contents are then don't-care because the pointer is 0.
- No combinational path from `s_inc`, `call`, `ret` or `stall` to any output.

## Configuration
- `FETCH_RET_STACK_EN` defined: the return stack and priorities 2–4 are implemented as above.
- Not defined:
  - No stack storage is built.
  - `call` behaves as a plain jump to the address field.
  - `ret` is ignored, so PC follows `s_inc`.
  - `err` is tied to 00 and HALTED is unreachable.

## Structure
- Shared package `fetch_pkg` holds:
  - state enum (BOOT, RUN, HALTED)
  - error codes `ERR_NONE`, `ERR_OVF`, `ERR_UNF`, `ERR_CONFLICT`
  - `NOP_OPCODE` = 6'b111111
  - opcode field width 6
- One sub-module, `ret_stack`:
  - LIFO of STACK_DEPTH×PC_WIDTH with push/pop, full/empty and top outputs
  - instantiated only under `FETCH_RET_STACK_EN`

## Test plan
- Reset, then run with `s_inc`=1 → `opcode`=111111 and `instr_valid`=0 for the boot cycle, then `pc`=0,1,2,3 on successive cycles.
- `mem_data`=16'h0005 at pc=2, `s_inc`=0 → `pc`=5 next cycle. Raising `stall` for 3 cycles → `pc` stays 5 with `instr_valid`=1.
- PC at 1023, `s_inc`=1 → `pc`=0. A call at 1023 with target 7 → `pc`=7; a later ret → `pc`=0.
- Stack depth 4 (macro on): 4 calls succeed, the 5th gives `err`=01, HALTED, `opcode`=111111, `pc` frozen. A ret on an empty stack gives `err`=10.
- `call`=`ret`=1 in RUN → `err`=11 and HALTED. `reset` pulse → `pc`=0, `err`=00, BOOT.
- Macro off: `call` at pc=3 with target 9 → `pc`=9; `ret` with `s_inc`=1 → `pc`=10; `err` stays 00.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage states, error codes and opcode constants
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam int OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 6'b111111;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;
endpackage

// File: rtl/pc_fetch_ret_stack.sv
// ret_stack: DEPTH x W LIFO of return addresses with full/empty flags
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] sp_q, sp_d;
  logic [AW-1:0] top_idx;
  assign sp_d = push ? sp_q + (AW+1)'(1) : pop ? sp_q - (AW+1)'(1) : sp_q;
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign top = mem_q[top_idx];
  assign full = sp_q[AW];
  assign empty = sp_q == '0;
  always_ff @(posedge clk) begin
    sp_q <= reset ? '0 : sp_d;
    if (push) mem_q[sp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC/fetch stage with boot, stall and optional FETCH_RET_STACK_EN return stack
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 10,
  parameter int INSTR_WIDTH = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   s_inc,
  input  logic                   stall,
  input  logic                   call,
  input  logic                   ret,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [OPCODE_W-1:0]    opcode,
  output logic                   instr_valid,
  output logic [1:0]             err
);
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, target;
  logic run;
  assign run = state_q == RUN;
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign target = mem_data[PC_WIDTH-1:0];
  assign pc = pc_q;
  assign instr_valid = run;
  assign instr = run ? mem_data : '0;
  assign opcode = run ? mem_data[INSTR_WIDTH-1 -: OPCODE_W] : NOP_OPCODE;
`ifdef FETCH_RET_STACK_EN
  logic [1:0] err_q, err_d;
  logic push, pop, full, empty;
  logic [PC_WIDTH-1:0] top;
  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_WIDTH)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_inc),
    .top(top), .full(full), .empty(empty)
  );
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    err_d = err_q;
    push = 1'b0;
    pop = 1'b0;
    if (state_q == BOOT) state_d = RUN;
    else if (run && !stall) begin
      if (call && ret) begin
        err_d = ERR_CONFLICT;
        state_d = HALTED;
      end else if (ret && empty) begin
        err_d = ERR_UNF;
        state_d = HALTED;
      end else if (ret) begin
        pc_d = top;
        pop = 1'b1;
      end else if (call && full) begin
        err_d = ERR_OVF;
        state_d = HALTED;
      end else if (call) begin
        pc_d = target;
        push = 1'b1;
      end else pc_d = s_inc ? pc_inc : target;
    end
  end
  always_ff @(posedge clk) err_q <= reset ? ERR_NONE : err_d;
`else
  logic unused_ret;
  assign unused_ret = ret | (STACK_DEPTH == 0);
  assign err = ERR_NONE;
  always_comb begin
    state_d = state_q == BOOT ? RUN : state_q;
    pc_d = (run && !stall) ? ((s_inc && !call) ? pc_inc : target) : pc_q;
  end
`endif
  always_ff @(posedge clk) begin
    state_q <= reset ? BOOT : state_d;
    pc_q <= reset ? '0 : pc_d;
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch
module tb_pc_fetch;
  logic clk = 1'b0, reset = 1'b1, s_inc = 1'b1, stall = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] mem [1024];
  logic [15:0] mem_data, instr;
  logic [9:0] pc;
  logic [5:0] opcode;
  logic instr_valid;
  logic [1:0] err;
  int total = 0, passed = 0;
  assign mem_data = mem[pc];
  always #5 clk = ~clk;
  pc_fetch dut (
    .clk(clk), .reset(reset), .mem_data(mem_data), .s_inc(s_inc), .stall(stall),
    .call(call), .ret(ret), .pc(pc), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .err(err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1; s_inc = 1'b1; stall = 1'b0; call = 1'b0; ret = 1'b0;
    step();
    reset = 1'b0;
  endtask
  task automatic chk_pc(input string name, input logic [9:0] exp);
    total++;
    if (pc !== exp) $display("FAIL %s pc=%0d expected=%0d", name, pc, exp);
    else passed++;
  endtask
  task automatic test_reset();
    mem[0] = 16'h1234;
    do_reset();
    total++;
    if ({pc, instr, opcode, instr_valid, err} !== {10'd0, 16'h0, 6'h3f, 1'b0, 2'b00})
      $display("FAIL reset pc=%0d instr=%h opcode=%h valid=%b err=%b expected 0/0000/3f/0/00",
               pc, instr, opcode, instr_valid, err);
    else passed++;
  endtask
  task automatic test_boot_and_inc();
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk_pc("boot_pc0", 10'd0);
    total++;
    if ({instr_valid, opcode, instr} !== {1'b1, 6'h04, 16'h1234})
      $display("FAIL first_instr valid=%b opcode=%h instr=%h expected 1/04/1234", instr_valid, opcode, instr);
    else passed++;
    step();
    chk_pc("inc_pc1", 10'd1);
    step();
    chk_pc("inc_pc2", 10'd2);
  endtask
  task automatic test_jump_stall();
    mem[2] = 16'h0005;
    s_inc = 1'b0;
    step();
    s_inc = 1'b1;
    chk_pc("jump_pc5", 10'd5);
    stall = 1'b1;
    s_inc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (pc !== 10'd5 || instr_valid !== 1'b1)
        $display("FAIL stall_hold pc=%0d valid=%b expected 5/1", pc, instr_valid);
      else passed++;
    end
    stall = 1'b0;
    s_inc = 1'b1;
    step();
    chk_pc("after_stall_pc6", 10'd6);
  endtask
  task automatic test_wrap();
    mem[6] = 16'h03ff;
    s_inc = 1'b0;
    step();
    s_inc = 1'b1;
    chk_pc("jump_pc1023", 10'd1023);
    step();
    chk_pc("wrap_pc0", 10'd0);
  endtask
`ifdef FETCH_RET_STACK_EN
  task automatic test_call_wrap_ret();
    do_reset();
    mem[0] = 16'h03ff;
    mem[1023] = 16'h0007;
    s_inc = 1'b0;
    step();
    step();
    chk_pc("stk_pc1023", 10'd1023);
    s_inc = 1'b1;
    call = 1'b1;
    step();
    call = 1'b0;
    chk_pc("call_at_1023", 10'd7);
    step();
    chk_pc("after_call_inc", 10'd8);
    ret = 1'b1;
    step();
    ret = 1'b0;
    chk_pc("ret_wrapped", 10'd0);
  endtask
  task automatic test_overflow();
    do_reset();
    mem[0] = 16'h0010; mem[16] = 16'h0020; mem[32] = 16'h0030; mem[48] = 16'h0040; mem[64] = 16'hfc50;
    step();
    call = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_pc("call_ok", 10'(16 * i));
    end
    step();
    call = 1'b0;
    total++;
    if ({err, instr_valid, opcode, pc} !== {2'b01, 1'b0, 6'h3f, 10'd64})
      $display("FAIL overflow err=%b valid=%b opcode=%h pc=%0d expected 01/0/3f/64", err, instr_valid, opcode, pc);
    else passed++;
    step();
    step();
    total++;
    if ({err, pc} !== {2'b01, 10'd64}) $display("FAIL halted_frozen err=%b pc=%0d expected 01/64", err, pc);
    else passed++;
  endtask
  task automatic test_underflow_conflict();
    do_reset();
    step();
    ret = 1'b1;
    step();
    ret = 1'b0;
    total++;
    if ({err, instr_valid} !== {2'b10, 1'b0}) $display("FAIL underflow err=%b valid=%b expected 10/0", err, instr_valid);
    else passed++;
    do_reset();
    step();
    stall = 1'b1; call = 1'b1; ret = 1'b1;
    step();
    total++;
    if ({err, instr_valid} !== {2'b00, 1'b1}) $display("FAIL conflict_stalled err=%b valid=%b expected 00/1", err, instr_valid);
    else passed++;
    stall = 1'b0;
    step();
    call = 1'b0; ret = 1'b0;
    total++;
    if ({err, instr_valid, pc} !== {2'b11, 1'b0, 10'd0})
      $display("FAIL conflict err=%b valid=%b pc=%0d expected 11/0/0", err, instr_valid, pc);
    else passed++;
    do_reset();
    total++;
    if ({err, pc, instr_valid} !== {2'b00, 10'd0, 1'b0})
      $display("FAIL reset_from_halt err=%b pc=%0d valid=%b expected 00/0/0", err, pc, instr_valid);
    else passed++;
  endtask
`else
  task automatic test_plain_call_ret();
    do_reset();
    mem[0] = 16'h0000; mem[3] = 16'h0009; mem[9] = 16'ha809;
    step();
    step();
    step();
    step();
    chk_pc("nostk_pc3", 10'd3);
    call = 1'b1;
    step();
    call = 1'b0;
    chk_pc("plain_call", 10'd9);
    total++;
    if (opcode !== 6'h2a) $display("FAIL call_opcode opcode=%h expected 2a", opcode);
    else passed++;
    ret = 1'b1;
    step();
    ret = 1'b0;
    chk_pc("ret_ignored", 10'd10);
    total++;
    if (err !== 2'b00) $display("FAIL err_tied err=%b expected 00", err);
    else passed++;
    stall = 1'b1; call = 1'b1;
    step();
    stall = 1'b0; call = 1'b0;
    chk_pc("stall_over_call", 10'd10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({pc, instr_valid, opcode} !== {10'd0, 1'b0, 6'h3f})
      $display("FAIL reset_mid_run pc=%0d valid=%b opcode=%h expected 0/0/3f", pc, instr_valid, opcode);
    else passed++;
  endtask
`endif
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    test_reset();
    test_boot_and_inc();
    test_jump_stall();
    test_wrap();
`ifdef FETCH_RET_STACK_EN
    test_call_wrap_ret();
    test_overflow();
    test_underflow_conflict();
`else
    test_plain_call_ret();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
